// File: rtl/mf_bank_seq.sv
// Sequential bank of N_MF trapezoid/shoulder membership functions sharing one divider.
// Latency: 1 + sum over MFs of (1 if flat, 17 if slope) cycles from accept to out_valid.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/x - crisp signed input handshake
//   cfg_we, cfg_idx, cfg_a..cfg_d, cfg_mode - breakpoint write (IDLE only), cfg_err on reject
//   out_valid/out_ready/mu_out - Q1.15 degrees, MF i in mu_out[16i+15:16i]
//   busy                - high whenever not IDLE
module mf_bank_seq #(
    parameter int XW   = 8,
    parameter int N_MF = 4,
    localparam int IW  = (N_MF > 1) ? $clog2(N_MF) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [XW-1:0]   x,
    input  logic                   cfg_we,
    input  logic [IW-1:0]          cfg_idx,
    input  logic signed [XW-1:0]   cfg_a,
    input  logic signed [XW-1:0]   cfg_b,
    input  logic signed [XW-1:0]   cfg_c,
    input  logic signed [XW-1:0]   cfg_d,
    input  logic [1:0]             cfg_mode,
    output logic                   cfg_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [16*N_MF-1:0]     mu_out,
    output logic                   busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] R_ZERO  = 2'd0;
    localparam logic [1:0] R_FULL  = 2'd1;
    localparam logic [1:0] R_LEFT  = 2'd2;
    localparam logic [1:0] R_RIGHT = 2'd3;

    // Dividend is a (XW+1)-bit difference shifted left by 15.
    localparam int DW = XW + 16;

    logic [1:0]                state_q, state_d;
    logic signed [XW-1:0]      x_q, x_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic signed [XW-1:0]      a_q [N_MF];
    logic signed [XW-1:0]      a_d [N_MF];
    logic signed [XW-1:0]      b_q [N_MF];
    logic signed [XW-1:0]      b_d [N_MF];
    logic signed [XW-1:0]      c_q [N_MF];
    logic signed [XW-1:0]      c_d [N_MF];
    logic signed [XW-1:0]      d_q [N_MF];
    logic signed [XW-1:0]      d_d [N_MF];
    logic [1:0]                mode_q [N_MF];
    logic [1:0]                mode_d [N_MF];
    logic [N_MF-1:0][15:0]     mu_q, mu_d;
    logic [DW-1:0]             rem_q, rem_d;
    logic [DW-1:0]             dsh_q, dsh_d;
    logic [14:0]               quo_q, quo_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      sat_q, sat_d;
    logic                      cfg_err_q, cfg_err_d;

    // Parameters of the MF currently being evaluated
    logic signed [XW-1:0]      cur_a, cur_b, cur_c, cur_d;
    logic [1:0]                cur_mode;
    logic [1:0]                region;
    logic [XW:0]               d_xa, d_ba, d_dx, d_dc;
    logic [XW:0]               num_diff, den;
    logic                      take;
    logic [15:0]               q_next;
    logic                      last_mf;
    logic                      cfg_idx_ok;
    logic                      adv;

    assign cur_a    = a_q[idx_q];
    assign cur_b    = b_q[idx_q];
    assign cur_c    = c_q[idx_q];
    assign cur_d    = d_q[idx_q];
    assign cur_mode = mode_q[idx_q];

    // Differences are sign-extended by one bit so extreme breakpoints never wrap.
    assign d_xa = {x_q[XW-1], x_q} - {cur_a[XW-1], cur_a};
    assign d_ba = {cur_b[XW-1], cur_b} - {cur_a[XW-1], cur_a};
    assign d_dx = {cur_d[XW-1], cur_d} - {x_q[XW-1], x_q};
    assign d_dc = {cur_d[XW-1], cur_d} - {cur_c[XW-1], cur_c};

    assign last_mf    = (idx_q == IW'(N_MF - 1));
    assign cfg_idx_ok = ({{(32-IW){1'b0}}, cfg_idx} < N_MF);

    // Region classification: rules are checked in order, first match wins.
    always_comb begin
        region = R_ZERO;
        case (cur_mode)
            2'd0: begin
                if (x_q <= cur_a || x_q >= cur_d)
                    region = R_ZERO;
                else if (x_q >= cur_b && x_q <= cur_c)
                    region = R_FULL;
                else if (x_q > cur_a && x_q < cur_b)
                    region = R_LEFT;
                else
                    region = R_RIGHT;
            end
            2'd1: begin
                if (x_q >= cur_d)
                    region = R_ZERO;
                else if (x_q <= cur_c)
                    region = R_FULL;
                else
                    region = R_RIGHT;
            end
            2'd2: begin
                if (x_q <= cur_a)
                    region = R_ZERO;
                else if (x_q >= cur_b)
                    region = R_FULL;
                else
                    region = R_LEFT;
            end
            default: region = R_ZERO;
        endcase
    end

    assign num_diff = (region == R_LEFT) ? d_xa : d_dx;
    assign den      = (region == R_LEFT) ? d_ba : d_dc;

    // Restoring step: the divisor is pre-shifted by 15 and walks right one bit
    // per cycle, so after 16 steps the quotient bits 15..0 are complete.
    assign take   = (rem_q >= dsh_q);
    assign q_next = {quo_q, take};

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        d_d       = d_q;
        mode_d    = mode_q;
        mu_d      = mu_q;
        rem_d     = rem_q;
        dsh_d     = dsh_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        cfg_err_d = 1'b0;
        adv       = 1'b0;

        if (cfg_we) begin
            if (state_q == S_IDLE && cfg_idx_ok) begin
                a_d[cfg_idx]    = cfg_a;
                b_d[cfg_idx]    = cfg_b;
                c_d[cfg_idx]    = cfg_c;
                d_d[cfg_idx]    = cfg_d;
                mode_d[cfg_idx] = cfg_mode;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    idx_d   = '0;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                case (region)
                    R_ZERO: begin
                        mu_d[idx_q] = 16'h0000;
                        adv         = 1'b1;
                    end
                    R_FULL: begin
                        mu_d[idx_q] = 16'h7FFF;
                        adv         = 1'b1;
                    end
                    default: begin
                        rem_d   = {num_diff, 15'b0};
                        dsh_d   = {den, 15'b0};
                        quo_d   = '0;
                        cnt_d   = '0;
                        // A quotient >= 2^16 (numerator >= 2*den) cannot be
                        // produced in 16 steps; flag it as saturated up front.
                        sat_d   = (den == '0) || ({1'b0, num_diff} >= {den, 1'b0});
                        state_d = S_DIV;
                    end
                endcase
            end
            S_DIV: begin
                rem_d = take ? (rem_q - dsh_q) : rem_q;
                dsh_d = dsh_q >> 1;
                quo_d = q_next[14:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    mu_d[idx_q] = (sat_q || q_next[15]) ? 16'h7FFF : q_next;
                    adv         = 1'b1;
                end
            end
            default: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
        endcase

        if (adv) begin
            if (last_mf) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + IW'(1);
                state_d = S_EVAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            idx_q     <= '0;
            mu_q      <= '0;
            rem_q     <= '0;
            dsh_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < N_MF; i++) begin
                a_q[i]    <= '0;
                b_q[i]    <= '0;
                c_q[i]    <= '0;
                d_q[i]    <= '0;
                mode_q[i] <= 2'd0;
            end
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            idx_q     <= idx_d;
            mu_q      <= mu_d;
            rem_q     <= rem_d;
            dsh_q     <= dsh_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            cfg_err_q <= cfg_err_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            d_q       <= d_d;
            mode_q    <= mode_d;
        end
    end

    // in_ready is masked by rst so nothing is offered while reset is applied.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign cfg_err   = cfg_err_q;
    assign mu_out    = mu_q;

endmodule

// File: tb/tb_mf_bank_seq.sv
// Directed self-checking bench for mf_bank_seq (default 4 MFs plus a 3-MF instance
// used to reach an out-of-range cfg_idx). Expected values are hand-computed.
module tb_mf_bank_seq;

    localparam int XW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [XW-1:0] x;
    logic                 cfg_we;
    logic [1:0]           cfg_idx;
    logic signed [XW-1:0] cfg_a, cfg_b, cfg_c, cfg_d;
    logic [1:0]           cfg_mode;
    logic                 cfg_err;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          mu_out;
    logic                 busy;

    logic                 in_valid3;
    logic                 in_ready3;
    logic                 cfg_we3;
    logic                 cfg_err3;
    logic                 out_valid3;
    logic [47:0]          mu_out3;
    logic                 busy3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    mf_bank_seq #(.XW(XW), .N_MF(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_c(cfg_c), .cfg_d(cfg_d), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
        .out_valid(out_valid), .out_ready(out_ready), .mu_out(mu_out), .busy(busy)
    );

    mf_bank_seq #(.XW(XW), .N_MF(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .x(x),
        .cfg_we(cfg_we3), .cfg_idx(cfg_idx), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_c(cfg_c), .cfg_d(cfg_d), .cfg_mode(cfg_mode), .cfg_err(cfg_err3),
        .out_valid(out_valid3), .out_ready(out_ready), .mu_out(mu_out3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mu4(input logic [15:0] m3, input logic [15:0] m2,
                                        input logic [15:0] m1, input logic [15:0] m0);
        return {m3, m2, m1, m0};
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic cfg_write(input int idx, input int a, input int b, input int c,
                             input int d, input int mode);
        cfg_we   = 1'b1;
        cfg_idx  = 2'(idx);
        cfg_a    = XW'(a);
        cfg_b    = XW'(b);
        cfg_c    = XW'(c);
        cfg_d    = XW'(d);
        cfg_mode = 2'(mode);
        tick();
        cfg_we = 1'b0;
        chk("cfg_ok_err", {63'd0, cfg_err}, 64'd0);
    endtask

    task automatic accept(input int xv);
        chk("acc_in_ready", {63'd0, in_ready}, 64'd1);
        x        = XW'(xv);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc      = 1;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [63:0] exp_mu);
        while (!out_valid && cyc < 100) tick();
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_mu"}, mu_out, exp_mu);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rel_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run(input string tag, input int xv, input int exp_lat,
                       input logic [63:0] exp_mu);
        accept(xv);
        wait_done(tag, exp_lat, exp_mu);
        release_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        logic [63:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        x         = '0;
        cfg_we    = 1'b0;
        cfg_we3   = 1'b0;
        cfg_idx   = '0;
        cfg_a     = '0;
        cfg_b     = '0;
        cfg_c     = '0;
        cfg_d     = '0;
        cfg_mode  = '0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
        chk("rst_mu", mu_out, 64'd0);
        chk("rst_mu3", {16'd0, mu_out3}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Trapezoid MF0
        cfg_write(0, 10, 20, 30, 40, 0);
        run("x15", 15, 21, mu4(16'h0, 16'h0, 16'h0, 16'h4000));
        run("x35", 35, 21, mu4(16'h0, 16'h0, 16'h0, 16'h4000));
        run("x25", 25, 5,  mu4(16'h0, 16'h0, 16'h0, 16'h7FFF));
        run("x40", 40, 5,  64'd0);
        run("x10", 10, 5,  64'd0);

        // Left shoulder MF1
        cfg_write(1, 0, 0, -50, -10, 1);
        run("xm100", -100, 5,  mu4(16'h0, 16'h0, 16'h7FFF, 16'h0));
        run("xm30",  -30,  21, mu4(16'h0, 16'h0, 16'h4000, 16'h0));
        run("x0",    0,    5,  64'd0);

        // Backpressure: DONE from cycle 5, out_ready low for 10 cycles
        accept(25);
        wait_done("bp", 5, mu4(16'h0, 16'h0, 16'h0, 16'h7FFF));
        held = mu_out;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        chk("bp_mu_stable", mu_out, held);
        release_out();
        chk("bp_idle_busy", {63'd0, busy}, 64'd0);
        chk("bp_mu_hold", mu_out, mu4(16'h0, 16'h0, 16'h0, 16'h7FFF));

        // Config write during DIV is rejected
        accept(15);
        tick();
        tick();
        tick();
        cfg_we   = 1'b1;
        cfg_idx  = 2'd0;
        cfg_a    = '0;
        cfg_b    = '0;
        cfg_c    = '0;
        cfg_d    = '0;
        cfg_mode = 2'd3;
        tick();
        cfg_we = 1'b0;
        chk("div_cfg_err", {63'd0, cfg_err}, 64'd1);
        tick();
        chk("div_cfg_err_pulse", {63'd0, cfg_err}, 64'd0);
        wait_done("divcfg", 21, mu4(16'h0, 16'h0, 16'h0, 16'h4000));
        release_out();
        run("divcfg_again", 15, 21, mu4(16'h0, 16'h0, 16'h0, 16'h4000));

        // Out-of-range index on the 3-MF instance
        cfg_we3  = 1'b1;
        cfg_idx  = 2'd3;
        cfg_mode = 2'd1;
        tick();
        cfg_we3 = 1'b0;
        chk("idx_cfg_err", {63'd0, cfg_err3}, 64'd1);
        tick();
        chk("idx_cfg_err_pulse", {63'd0, cfg_err3}, 64'd0);
        cfg_we3 = 1'b1;
        cfg_idx = 2'd2;
        tick();
        cfg_we3 = 1'b0;
        chk("idx_ok_err", {63'd0, cfg_err3}, 64'd0);
        chk("d3_idle", {63'd0, in_ready3 & ~busy3 & ~out_valid3}, 64'd1);

        // Reset in the 8th DIV cycle (DIV spans cycles 2..17)
        accept(15);
        while (cyc < 9) tick();
        rst = 1'b1;
        #1;
        chk("rst_div_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_div_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_div_busy", {63'd0, busy}, 64'd0);
        chk("rst_div_mu", mu_out, 64'd0);
        chk("rst_div_in_ready1", {63'd0, in_ready}, 64'd1);
        run("post_rst_x25", 25, 5, 64'd0);

        // cfg_we and in_valid in the same IDLE cycle: new MF2 params apply
        cfg_we   = 1'b1;
        cfg_idx  = 2'd2;
        cfg_a    = XW'(0);
        cfg_b    = XW'(40);
        cfg_c    = XW'(50);
        cfg_d    = XW'(60);
        cfg_mode = 2'd2;
        accept(10);
        cfg_we = 1'b0;
        chk("coinc_cfg_err", {63'd0, cfg_err}, 64'd0);
        wait_done("coinc", 21, mu4(16'h0, 16'h2000, 16'h0, 16'h0));
        release_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
